// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer beside the EX ALU, owning HI/LO.
// Define EX_MULDIV_DIV_EN to build the restoring divider; otherwise divides retire as no-ops.
module ex_muldiv_seq #(
    parameter int NB_DATA = 32
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_step,
    input  logic               i_start,
    input  logic [1:0]         i_op,
    input  logic [NB_DATA-1:0] i_data_A,
    input  logic [NB_DATA-1:0] i_data_B,
    output logic               o_stall,
    output logic               o_done,
    output logic               o_div_zero,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);
    localparam int CW = (NB_DATA > 2) ? $clog2(NB_DATA) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(NB_DATA - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;
    state_t state_reg, state_next;

    logic [CW-1:0]        cnt_reg;
    logic [NB_DATA-1:0]   mcand_reg;   // multiplicand, or divisor magnitude
    logic [2*NB_DATA-1:0] acc_reg;     // product, or {remainder, dividend->quotient}
    logic                 neg_res_reg;
    logic [NB_DATA-1:0]   hi_reg, lo_reg;
    logic                 stall_raw, done_raw;

    logic               op_signed, op_div, a_neg, b_neg;
    logic [NB_DATA-1:0] a_mag, b_mag;

    assign op_signed = ~i_op[0];
    assign op_div    = i_op[1];
    assign a_neg     = op_signed & i_data_A[NB_DATA-1];
    assign b_neg     = op_signed & i_data_B[NB_DATA-1];
    assign a_mag     = a_neg ? -i_data_A : i_data_A;
    assign b_mag     = b_neg ? -i_data_B : i_data_B;

    // Radix-2 shift-add step: add into the upper half, then shift the whole accumulator right.
    logic [NB_DATA:0]     mul_sum;
    logic [2*NB_DATA-1:0] mul_next, prod_fix;
    assign mul_sum  = {1'b0, acc_reg[2*NB_DATA-1:NB_DATA]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[NB_DATA-1:1]};
    assign prod_fix = neg_res_reg ? -acc_reg : acc_reg;

`ifdef EX_MULDIV_DIV_EN
    logic                 div_op_reg, neg_rem_reg, div_zero_reg, b_zero;
    logic [NB_DATA:0]     div_shift;
    logic [NB_DATA-1:0]   div_diff, quo_fix, rem_fix;
    logic                 div_ge;
    logic [2*NB_DATA-1:0] div_next;

    assign b_zero    = (i_data_B == '0);
    assign div_shift = {acc_reg[2*NB_DATA-1:NB_DATA], acc_reg[NB_DATA-1]};
    assign div_ge    = (div_shift >= {1'b0, mcand_reg});
    // When the trial subtract succeeds the true difference is below the divisor, so N bits suffice.
    assign div_diff  = div_shift[NB_DATA-1:0] - mcand_reg;
    assign div_next  = div_ge ? {div_diff, acc_reg[NB_DATA-2:0], 1'b1}
                              : {div_shift[NB_DATA-1:0], acc_reg[NB_DATA-2:0], 1'b0};
    assign quo_fix   = neg_res_reg ? -acc_reg[NB_DATA-1:0] : acc_reg[NB_DATA-1:0];
    assign rem_fix   = neg_rem_reg ? -acc_reg[2*NB_DATA-1:NB_DATA] : acc_reg[2*NB_DATA-1:NB_DATA];
`endif

    always_comb begin
        state_next = state_reg;
        stall_raw  = 1'b0;
        done_raw   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (i_start) begin
                    stall_raw = 1'b1;
                    if (!op_div)
                        state_next = S_MUL;
`ifdef EX_MULDIV_DIV_EN
                    else if (b_zero)
                        state_next = S_DONE;
                    else
                        state_next = S_DIV;
`else
                    else
                        state_next = S_DONE;
`endif
                end
            end
            S_MUL: begin
                stall_raw = 1'b1;
                if (cnt_reg == LAST_ITER)
                    state_next = S_FIX;
            end
`ifdef EX_MULDIV_DIV_EN
            S_DIV: begin
                stall_raw = 1'b1;
                if (cnt_reg == LAST_ITER)
                    state_next = S_FIX;
            end
`endif
            S_FIX: begin
                stall_raw  = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                done_raw   = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            state_reg <= S_IDLE;
        else if (i_step)
            state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_reg      <= '0;
            mcand_reg    <= '0;
            acc_reg      <= '0;
            neg_res_reg  <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
`ifdef EX_MULDIV_DIV_EN
            div_op_reg   <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
`endif
        end else if (i_step) begin
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        cnt_reg     <= '0;
                        neg_res_reg <= a_neg ^ b_neg;
                        mcand_reg   <= op_div ? b_mag : a_mag;
                        acc_reg     <= {{NB_DATA{1'b0}}, (op_div ? a_mag : b_mag)};
`ifdef EX_MULDIV_DIV_EN
                        div_op_reg   <= op_div;
                        neg_rem_reg  <= a_neg;
                        div_zero_reg <= op_div & b_zero;
                        if (op_div && b_zero) begin
                            hi_reg <= i_data_A;
                            lo_reg <= '1;
                        end
`endif
                    end
                end
                S_MUL: begin
                    acc_reg <= mul_next;
                    cnt_reg <= cnt_reg + CW'(1);
                end
`ifdef EX_MULDIV_DIV_EN
                S_DIV: begin
                    acc_reg <= div_next;
                    cnt_reg <= cnt_reg + CW'(1);
                end
`endif
                S_FIX: begin
`ifdef EX_MULDIV_DIV_EN
                    if (div_op_reg) begin
                        hi_reg <= rem_fix;
                        lo_reg <= quo_fix;
                    end else
`endif
                    begin
                        hi_reg <= prod_fix[2*NB_DATA-1:NB_DATA];
                        lo_reg <= prod_fix[NB_DATA-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset must silence the stall even while EX still presents i_start.
    assign o_stall = stall_raw & i_reset;
    assign o_done  = done_raw;
    assign o_hi    = hi_reg;
    assign o_lo    = lo_reg;
`ifdef EX_MULDIV_DIV_EN
    assign o_div_zero = done_raw & div_zero_reg;
`else
    assign o_div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Testbench for ex_muldiv_seq: directed vector table, step-freeze and reset corner cases,
// then random operations checked against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_ex_muldiv_seq;
    localparam int NB      = 32;
    localparam int MAX_CYC = 200;
    localparam int N_RAND  = 40;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_step = 1'b1;
    logic          i_start = 1'b0;
    logic [1:0]    i_op = 2'b00;
    logic [NB-1:0] i_data_A = '0;
    logic [NB-1:0] i_data_B = '0;
    logic          o_stall, o_done, o_div_zero;
    logic [NB-1:0] o_hi, o_lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NB-1:0] mdl_hi = '0;
    logic [NB-1:0] mdl_lo = '0;

    ex_muldiv_seq #(.NB_DATA(NB)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_step     (i_step),
        .i_start    (i_start),
        .i_op       (i_op),
        .i_data_A   (i_data_A),
        .i_data_B   (i_data_B),
        .o_stall    (o_stall),
        .o_done     (o_done),
        .o_div_zero (o_div_zero),
        .o_hi       (o_hi),
        .o_lo       (o_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [NB-1:0] a, b, hi, lo;
        logic          dz;
        int            lat;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: full-width integer arithmetic straight from the operation definitions.
    task automatic ref_op(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b,
                          inout logic [NB-1:0] hi, inout logic [NB-1:0] lo,
                          output logic dz, output int lat);
        longint sa, sb, sp, sq, sr;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dz  = 1'b0;
        lat = NB + 2;
        case (op)
            2'b00: begin
                sp = sa * sb;
                {hi, lo} = sp;
            end
            2'b01: begin
                up = {32'b0, a} * {32'b0, b};
                {hi, lo} = up;
            end
            default: begin
`ifdef EX_MULDIV_DIV_EN
                if (b == 0) begin
                    dz = 1'b1; lat = 1; hi = a; lo = '1;
                end else if (op == 2'b10) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    hi = sr[NB-1:0];
                    lo = sq[NB-1:0];
                end else begin
                    hi = a % b;
                    lo = a / b;
                end
`else
                lat = 1;
`endif
            end
        endcase
    endtask

    // Starts at a falling edge; returns at the falling edge after DONE (an IDLE cycle).
    task automatic run_op(input string tag, input logic [1:0] op, input logic [NB-1:0] a,
                          input logic [NB-1:0] b, input int exp_lat, input logic [NB-1:0] exp_hi,
                          input logic [NB-1:0] exp_lo, input logic exp_dz,
                          input int freeze_at, input int freeze_len);
        int cyc, stall_cycles;
        bit seen;
        i_op = op; i_data_A = a; i_data_B = b; i_start = 1'b1;
        #1;
        check({tag, ".stall0"}, o_stall, 1);
        stall_cycles = o_stall ? 1 : 0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) i_start = 1'b0;
            if (freeze_len > 0 && cyc == freeze_at) i_step = 1'b0;
            if (freeze_len > 0 && cyc == freeze_at + freeze_len) i_step = 1'b1;
            #1;
            if (o_done) seen = 1;
            else if (o_stall) stall_cycles++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: actual no o_done required o_done within %0d cycles", tag, MAX_CYC);
            i_step = 1'b1;
        end else begin
            check({tag, ".latency"}, cyc, exp_lat);
            check({tag, ".stall_cycles"}, stall_cycles, exp_lat);
            check({tag, ".stall_done"}, o_stall, 0);
            check({tag, ".hi"}, o_hi, exp_hi);
            check({tag, ".lo"}, o_lo, exp_lo);
            check({tag, ".div_zero"}, o_div_zero, exp_dz);
        end
        $display("op=%0d A=0x%08h B=0x%08h cycles=%0d hi=0x%08h lo=0x%08h dz=%0d [%s]",
                 op, a, b, cyc, o_hi, o_lo, o_div_zero, tag);
        @(negedge clk);
        #1;
        check({tag, ".done_clear"}, o_done, 0);
        check({tag, ".hold"}, {o_hi, o_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] e_hi, e_lo, ra, rb, prev_hi, prev_lo;
        logic          e_dz;
        int            e_lat;
        logic [1:0]    rop;

        vecs[0] = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
        vecs[2] = '{2'b00, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 1'b0, 34};
        vecs[3] = '{2'b01, 32'd7,        32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB, 1'b0, 34};
        vecs[4] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
        vecs[5] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[7] = '{2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1};
`ifndef EX_MULDIV_DIV_EN
        // Without the divider every divide retires in one stall cycle leaving HI/LO untouched.
        prev_hi = '0;
        prev_lo = '0;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].op[1]) begin
                vecs[i].hi = prev_hi; vecs[i].lo = prev_lo; vecs[i].dz = 1'b0; vecs[i].lat = 1;
            end
            prev_hi = vecs[i].hi;
            prev_lo = vecs[i].lo;
        end
`endif

        // Async reset with i_start held high: stall must stay low.
        i_start = 1'b1; i_op = 2'b00; i_data_A = 32'd7; i_data_B = 32'd3;
        #2 i_reset = 1'b0;
        #1;
        check("reset.stall", o_stall, 0);
        check("reset.done", o_done, 0);
        check("reset.div_zero", o_div_zero, 0);
        check("reset.hilo", {o_hi, o_lo}, 64'h0);
        repeat (3) @(negedge clk);
        #1;
        check("reset.stall_clocked", o_stall, 0);
        check("reset.done_clocked", o_done, 0);
        @(negedge clk);
        i_start = 1'b0;
        i_reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat,
                   vecs[i].hi, vecs[i].lo, vecs[i].dz, 0, 0);
            mdl_hi = vecs[i].hi;
            mdl_lo = vecs[i].lo;
        end

        // Same MULT twice: once free-running, once frozen for 10 cycles mid-iteration.
        ra = 32'h1234_5678; rb = 32'hFEDC_BA98;
        e_hi = mdl_hi; e_lo = mdl_lo;
        ref_op(2'b00, ra, rb, e_hi, e_lo, e_dz, e_lat);
        run_op("mul_free", 2'b00, ra, rb, e_lat, e_hi, e_lo, e_dz, 0, 0);
        run_op("mul_frozen", 2'b00, ra, rb, e_lat + 10, e_hi, e_lo, e_dz, 5, 10);
        mdl_hi = e_hi; mdl_lo = e_lo;

        // Reset at iteration 15 of a long operation, then a fresh MULT from IDLE.
        run_op("pre_reset", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 32'hFFFFFFFE, 32'h1, 1'b0, 0, 0);
`ifdef EX_MULDIV_DIV_EN
        i_op = 2'b10;
`else
        i_op = 2'b01;
`endif
        i_data_A = 32'hDEADBEEF; i_data_B = 32'd13; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (14) @(negedge clk);
        i_reset = 1'b0;
        #1;
        check("midreset.stall", o_stall, 0);
        check("midreset.done", o_done, 0);
        check("midreset.hilo", {o_hi, o_lo}, 64'h0);
        @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        run_op("post_reset", 2'b00, 32'd3, 32'd4, 34, 32'd0, 32'd12, 1'b0, 0, 0);
        mdl_hi = 32'd0; mdl_lo = 32'd12;

        for (int n = 0; n < N_RAND; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h80000000;
                3: rb = 32'hFFFFFFFF;
                default: ;
            endcase
            e_hi = mdl_hi; e_lo = mdl_lo;
            ref_op(rop, ra, rb, e_hi, e_lo, e_dz, e_lat);
            run_op($sformatf("rand%0d", n), rop, ra, rb, e_lat, e_hi, e_lo, e_dz, 0, 0);
            mdl_hi = e_hi; mdl_lo = e_lo;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
